// File: rtl/image_buffer_pkg.sv
// Shared types and constants for the camera frame buffer arbiter.
package image_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   localparam int unsigned LAST_WORD_ADDRESS = 16383;
   localparam int unsigned READ_LATENCY      = 3;

endpackage

// File: rtl/image_buffer_arbiter.sv
// Arbitrates camera word writes and host byte reads onto one
// single-port frame buffer, with a one-entry skid for write stalls.
module image_buffer_arbiter
   import image_buffer_pkg::*;
(
   input  logic        clock_in,
   input  logic        reset_n_in,
   input  logic        capture_start_in,
   input  logic [31:0] pixel_data_in,
   input  logic        pixel_valid_in,
   input  logic        frame_end_in,
   input  logic        read_request_in,
   input  logic [15:0] read_address_in,
   output logic        read_ready_out,
   output logic [7:0]  read_data_out,
   output logic        read_valid_out,
   output logic        capture_done_out,
   output logic [14:0] word_count_out,
   output logic        overflow_out,
   output logic [15:0] buffer_write_address_out,
   output logic [15:0] buffer_read_address_out,
   output logic [31:0] buffer_write_data_out,
   output logic        buffer_write_read_n_out,
   input  logic [7:0]  buffer_read_data_in
);

   localparam logic [14:0] LAST_WORD = 15'(LAST_WORD_ADDRESS);

   state_e                  state_q, state_d;
   logic [14:0]             word_count_q, word_count_d;
   logic                    overflow_q, overflow_d;
   logic                    skid_full_q, skid_full_d;
   logic [31:0]             skid_data_q, skid_data_d;
   logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
   logic [15:0]             rd_addr_q, rd_addr_d;
   logic [7:0]              rd_data_q, rd_data_d;
   logic                    ready_en_q;

   logic        in_word;
   logic        wr_slot;
   logic        wr_req;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        accept;

   assign read_ready_out = ready_en_q && !(|rd_pipe_q)
                           && !skid_full_q && !pixel_valid_in;
   assign accept         = read_request_in && read_ready_out;

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;
      skid_full_d  = skid_full_q;
      skid_data_d  = skid_data_q;
      wr_req       = 1'b0;
      wr_en        = 1'b0;
      wr_data      = pixel_data_in;
      in_word      = pixel_valid_in && (state_q == ST_CAPTURE);
      // The read address cycle owns the buffer port.
      wr_slot      = !rd_pipe_q[0];

      if (skid_full_q) begin
         if (wr_slot) begin
            wr_req      = 1'b1;
            wr_data     = skid_data_q;
            skid_full_d = in_word;
            skid_data_d = pixel_data_in;
         end
      end else if (in_word) begin
         if (wr_slot) begin
            wr_req = 1'b1;
         end else begin
            skid_full_d = 1'b1;
            skid_data_d = pixel_data_in;
         end
      end

      if (wr_req) begin
         if (word_count_q > LAST_WORD) begin
            overflow_d = 1'b1;
         end else begin
            wr_en        = 1'b1;
            word_count_d = word_count_q + 15'd1;
         end
      end

      unique case (state_q)
         ST_CAPTURE: begin
            if (frame_end_in) state_d = ST_DONE;
         end
         default: begin
            if (capture_start_in) begin
               state_d      = ST_CAPTURE;
               word_count_d = '0;
               overflow_d   = 1'b0;
            end
         end
      endcase

      rd_pipe_d = {rd_pipe_q[READ_LATENCY-2:0], accept};
      rd_addr_d = accept ? read_address_in : rd_addr_q;
      rd_data_d = rd_pipe_q[1] ? buffer_read_data_in : rd_data_q;
   end

   always_ff @(posedge clock_in) begin
      if (!reset_n_in) begin
         state_q      <= ST_IDLE;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
         skid_full_q  <= 1'b0;
         skid_data_q  <= '0;
         rd_pipe_q    <= '0;
         rd_addr_q    <= '0;
         rd_data_q    <= '0;
         ready_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
         skid_full_q  <= skid_full_d;
         skid_data_q  <= skid_data_d;
         rd_pipe_q    <= rd_pipe_d;
         rd_addr_q    <= rd_addr_d;
         rd_data_q    <= rd_data_d;
         ready_en_q   <= 1'b1;
      end
   end

   assign read_data_out            = rd_data_q;
   assign read_valid_out           = rd_pipe_q[READ_LATENCY-1];
   assign capture_done_out         = (state_q == ST_DONE) && !skid_full_q;
   assign word_count_out           = word_count_q;
   assign overflow_out             = overflow_q;
   assign buffer_write_address_out = {2'b00, word_count_q[13:0]};
   assign buffer_read_address_out  = rd_addr_q;
   assign buffer_write_data_out    = wr_en ? wr_data : '0;
   assign buffer_write_read_n_out  = wr_en;

endmodule

// File: tb/tb_image_buffer_arbiter.sv
// Directed bench for image_buffer_arbiter with a synchronous
// byte-read buffer model.
module tb_image_buffer_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cs;
   logic [31:0] pd;
   logic        pv;
   logic        fe;
   logic        rq;
   logic [15:0] ra;
   logic        ready;
   logic [7:0]  rdata;
   logic        valid;
   logic        done;
   logic [14:0] count;
   logic        ovf;
   logic [15:0] waddr;
   logic [15:0] raddr;
   logic [31:0] wdata;
   logic        wrn;
   logic [7:0]  rbyte;

   logic [31:0] mem [0:16383];

   int checks = 0;
   int errors = 0;

   image_buffer_arbiter dut (
      .clock_in                 (clk),
      .reset_n_in               (rst_n),
      .capture_start_in         (cs),
      .pixel_data_in            (pd),
      .pixel_valid_in           (pv),
      .frame_end_in             (fe),
      .read_request_in          (rq),
      .read_address_in          (ra),
      .read_ready_out           (ready),
      .read_data_out            (rdata),
      .read_valid_out           (valid),
      .capture_done_out         (done),
      .word_count_out           (count),
      .overflow_out             (ovf),
      .buffer_write_address_out (waddr),
      .buffer_read_address_out  (raddr),
      .buffer_write_data_out    (wdata),
      .buffer_write_read_n_out  (wrn),
      .buffer_read_data_in      (rbyte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wrn) mem[waddr[13:0]] <= wdata;
      rbyte <= 8'(mem[raddr[15:2]] >> {raddr[1:0], 3'b000});
   end

   typedef struct {
      logic        rst_n, cs, pv, fe, rq;
      logic [31:0] pd;
      logic [15:0] ra;
      logic        e_ready, e_wrn;
      logic [15:0] e_waddr;
      logic [31:0] e_wdata;
      logic [14:0] e_count;
      logic        e_done, e_valid;
      logic [7:0]  e_rdata;
      logic        rchk;
      logic [15:0] e_raddr;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(
      input logic [31:0] a_rst, a_cs, a_pv, a_pd, a_fe, a_rq, a_ra,
      input logic [31:0] x_rdy, x_wrn, x_wa, x_wd, x_cnt, x_done,
      input logic [31:0] x_val, x_rd, x_rc, x_ra);
      vec_t v;
      v.rst_n   = a_rst[0];
      v.cs      = a_cs[0];
      v.pv      = a_pv[0];
      v.pd      = a_pd;
      v.fe      = a_fe[0];
      v.rq      = a_rq[0];
      v.ra      = a_ra[15:0];
      v.e_ready = x_rdy[0];
      v.e_wrn   = x_wrn[0];
      v.e_waddr = x_wa[15:0];
      v.e_wdata = x_wd;
      v.e_count = x_cnt[14:0];
      v.e_done  = x_done[0];
      v.e_valid = x_val[0];
      v.e_rdata = x_rd[7:0];
      v.rchk    = x_rc[0];
      v.e_raddr = x_ra[15:0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " ready"}, 32'(ready), 0);
      chk({tag, " rdata"}, 32'(rdata), 0);
      chk({tag, " valid"}, 32'(valid), 0);
      chk({tag, " done"},  32'(done),  0);
      chk({tag, " count"}, 32'(count), 0);
      chk({tag, " ovf"},   32'(ovf),   0);
      chk({tag, " waddr"}, 32'(waddr), 0);
      chk({tag, " raddr"}, 32'(raddr), 0);
      chk({tag, " wdata"}, wdata,      0);
      chk({tag, " wrn"},   32'(wrn),   0);
   endtask

   initial begin
      int n;
      logic seen;

      //          rst cs pv pd           fe rq ra
      //          rdy wrn wa wd          cnt dn vl rd   rc ra
      vecs[0]  = mk(1, 1, 0, 0,           0, 0, 0,
                    1, 0, 0, 0,           0, 0, 0, 0,    0, 0);
      vecs[1]  = mk(1, 0, 1, 32'h11223344, 0, 0, 0,
                    0, 1, 0, 32'h11223344, 0, 0, 0, 0,    0, 0);
      vecs[2]  = mk(1, 0, 1, 32'h22334455, 0, 0, 0,
                    0, 1, 1, 32'h22334455, 1, 0, 0, 0,    0, 0);
      vecs[3]  = mk(1, 0, 1, 32'h33445566, 0, 0, 0,
                    0, 1, 2, 32'h33445566, 2, 0, 0, 0,    0, 0);
      vecs[4]  = mk(1, 0, 1, 32'h44556677, 1, 0, 0,
                    0, 1, 3, 32'h44556677, 3, 0, 0, 0,    0, 0);
      vecs[5]  = mk(1, 0, 0, 0,           0, 0, 0,
                    1, 0, 0, 0,           4, 1, 0, 0,    0, 0);
      vecs[6]  = mk(0, 0, 0, 0,           0, 0, 0,
                    1, 0, 0, 0,           4, 1, 0, 0,    0, 0);
      vecs[7]  = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 0, 0, 0,           0, 0, 0, 0,    1, 0);
      vecs[8]  = mk(1, 0, 0, 0,           0, 1, 16'h0006,
                    1, 0, 0, 0,           0, 0, 0, 0,    0, 0);
      vecs[9]  = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 0, 0, 0,           0, 0, 0, 0,    1, 16'h0006);
      vecs[10] = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 0, 0, 0,           0, 0, 0, 0,    1, 16'h0006);
      vecs[11] = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 0, 0, 0,           0, 0, 1, 8'h33, 0, 0);
      vecs[12] = mk(1, 1, 0, 0,           0, 1, 16'h000D,
                    1, 0, 0, 0,           0, 0, 0, 0,    0, 0);
      vecs[13] = mk(1, 0, 1, 32'hA0A1A2A3, 0, 0, 0,
                    0, 0, 0, 0,           0, 0, 0, 0,    1, 16'h000D);
      vecs[14] = mk(1, 0, 1, 32'hB0B1B2B3, 0, 0, 0,
                    0, 1, 0, 32'hA0A1A2A3, 0, 0, 0, 0,    1, 16'h000D);
      vecs[15] = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 1, 1, 32'hB0B1B2B3, 1, 0, 1, 8'h66, 0, 0);
      vecs[16] = mk(1, 0, 0, 0,           1, 0, 0,
                    1, 0, 0, 0,           2, 0, 0, 0,    0, 0);
      vecs[17] = mk(1, 0, 0, 0,           0, 0, 0,
                    1, 0, 0, 0,           2, 1, 0, 0,    0, 0);
      vecs[18] = mk(1, 0, 0, 0,           0, 1, 16'h0001,
                    1, 0, 0, 0,           2, 1, 0, 0,    0, 0);
      vecs[19] = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 0, 0, 0,           2, 1, 0, 0,    1, 16'h0001);
      vecs[20] = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 0, 0, 0,           2, 1, 0, 0,    1, 16'h0001);
      vecs[21] = mk(1, 0, 0, 0,           0, 0, 0,
                    0, 0, 0, 0,           2, 1, 1, 8'hA2, 0, 0);
      vecs[22] = mk(1, 0, 1, 32'hDEADBEEF, 0, 0, 0,
                    0, 0, 0, 0,           2, 1, 0, 0,    0, 0);
      vecs[23] = mk(1, 0, 0, 0,           0, 0, 0,
                    1, 0, 0, 0,           2, 1, 0, 0,    0, 0);

      rst_n = 1'b0; cs = 1'b0; pd = '0; pv = 1'b0;
      fe = 1'b0; rq = 1'b0; ra = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready first cycle", 32'(ready), 0);
      @(negedge clk);
      #1;
      chk("ready after reset", 32'(ready), 1);

      // Table: capture, idle read, skid read, done read
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n;
         cs    = vecs[i].cs;
         pv    = vecs[i].pv;
         pd    = vecs[i].pd;
         fe    = vecs[i].fe;
         rq    = vecs[i].rq;
         ra    = vecs[i].ra;
         #1;
         chk($sformatf("row%0d ready", i), 32'(ready), 32'(vecs[i].e_ready));
         chk($sformatf("row%0d wrn", i), 32'(wrn), 32'(vecs[i].e_wrn));
         chk($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].e_count));
         chk($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].e_done));
         chk($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].e_valid));
         if (vecs[i].e_wrn) begin
            chk($sformatf("row%0d waddr", i), 32'(waddr), 32'(vecs[i].e_waddr));
            chk($sformatf("row%0d wdata", i), wdata, vecs[i].e_wdata);
         end
         if (vecs[i].e_valid)
            chk($sformatf("row%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
         if (vecs[i].rchk)
            chk($sformatf("row%0d raddr", i), 32'(raddr), 32'(vecs[i].e_raddr));
      end

      // Overflow: 16385 words into a 16384-word buffer
      @(negedge clk);
      pv = 1'b0; cs = 1'b1;
      @(negedge clk);
      cs = 1'b0;
      for (int i = 0; i < 16385; i++) begin
         pv = 1'b1;
         pd = 32'(i + 1);
         if (i == 16384) begin
            #1;
            chk("ovf drop wrn", 32'(wrn), 0);
            chk("ovf before drop", 32'(ovf), 0);
            chk("ovf full count", 32'(count), 16384);
         end
         @(negedge clk);
      end
      pv = 1'b0; fe = 1'b1;
      @(negedge clk);
      fe = 1'b0;
      #1;
      chk("ovf count", 32'(count), 16384);
      chk("ovf flag", 32'(ovf), 1);
      chk("ovf done", 32'(done), 1);
      chk("ovf mem0", mem[0], 1);
      chk("ovf mem last", mem[16383], 16384);
      rq = 1'b1; ra = 16'h0000;
      #1;
      chk("ovf read ready", 32'(ready), 1);
      n = 0;
      do begin
         @(negedge clk);
         rq = 1'b0;
         #1;
         n++;
      end while (!valid && n < 8);
      chk("ovf read latency", 32'(n), 3);
      chk("ovf read byte", 32'(rdata), 8'h01);

      // Reset mid-capture with a read in flight
      @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      cs = 1'b0; pv = 1'b1; pd = 32'h55;
      @(negedge clk);
      pd = 32'h66;
      @(negedge clk);
      pv = 1'b0; rq = 1'b1; ra = 16'h0004;
      #1;
      chk("midrst ready", 32'(ready), 1);
      @(negedge clk);
      rq = 1'b0; rst_n = 1'b0; pv = 1'b1; pd = 32'h77;
      @(negedge clk);
      rst_n = 1'b1; pv = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pv = 1'b1; pd = 32'h88;
         #1;
         if (valid || wrn) seen = 1'b1;
      end
      chk("midrst quiet", 32'(seen), 0);
      chk("midrst count", 32'(count), 0);
      pv = 1'b0;
      #1;
      chk("midrst ready back", 32'(ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/image_buffer_arbiter.md
IMAGE_BUFFER_ARBITER -- requirements
Module: image_buffer_arbiter

Interface
REQ-001 The port list SHALL be exactly as given in REQ-002 to REQ-018, with one clock and a synchronous, active-low reset.
REQ-002 clock_in  input  1  sole clock for all state.
REQ-003 reset_n_in  input  1  synchronous active-low reset.
REQ-004 capture_start_in  input  1  single-cycle pulse that starts a frame capture.
REQ-005 pixel_data_in  input  32  four packed bytes from the camera pipeline.
REQ-006 pixel_valid_in  input  1  pixel_data_in is valid this cycle; no backpressure.
REQ-007 frame_end_in  input  1  single-cycle pulse marking the end of the frame.
REQ-008 read_request_in  input  1  host byte-read request.
REQ-009 read_address_in  input  16  byte address for the host read.
REQ-010 read_ready_out  output  1  a read can be accepted this cycle.
REQ-011 read_data_out  output  8  returned byte.
REQ-012 read_valid_out  output  1  read_data_out is valid; one-cycle pulse.
REQ-013 capture_done_out  output  1  the frame is completely written.
REQ-014 word_count_out  output  15  number of 32-bit words written this frame (0 to 16384).
REQ-015 overflow_out  output  1  at least one word was dropped because the buffer was full.
REQ-016 buffer_write_address_out  output  16  word address to the buffer; bits [15:14] SHALL be 0.
REQ-017 buffer_read_address_out  output  16  byte address to the buffer; bits [15:2] select the word, bits [1:0] select the byte.
REQ-018 buffer_write_data_out  output  32; buffer_write_read_n_out  output  1 (1 = write); buffer_read_data_in  input  8.

Function
REQ-019 States SHALL be IDLE, CAPTURE and DONE.
- IDLE/DONE -> CAPTURE on capture_start_in.
- CAPTURE -> DONE on frame_end_in.
- capture_start_in while in CAPTURE SHALL be ignored; frame_end_in while in IDLE or DONE SHALL be ignored.
REQ-020 Entering CAPTURE SHALL clear the write address, word_count_out and overflow_out, and SHALL deassert capture_done_out.
REQ-021 In CAPTURE, each pixel_valid_in word SHALL be written to the buffer exactly once, in arrival order, at consecutive word addresses from 0.
- word_count_out increments on each buffer write.
- pixel_valid_in outside CAPTURE SHALL be discarded.
REQ-022 A word arriving after address 16383 has been written SHALL be dropped, SHALL set overflow_out, and SHALL NOT change word_count_out; the address SHALL NOT wrap.
REQ-023 A pixel_valid_in coinciding with frame_end_in SHALL be written and counted.
REQ-024 Read handshake:
- a read is accepted at cycle N when read_request_in && read_ready_out;
- read_address_in is registered onto buffer_read_address_out during N+1 and held through N+2;
- buffer_write_read_n_out = 0 during N+1;
- the byte is sampled at the end of N+2;
- read_data_out and read_valid_out are valid during N+3 only.
- Latency SHALL be 3 cycles.
REQ-025 read_ready_out SHALL be 0 while a read is in flight (N+1 to N+3), while the skid register is full, or while pixel_valid_in is high.
REQ-026 A one-entry skid register SHALL hold a word that arrives during a read address cycle (N+1); that word SHALL be written at N+2.
- Writes otherwise SHALL take priority, and no word SHALL be lost at one word per cycle.
REQ-027 capture_done_out SHALL be 1 only when in DONE and the skid register is empty.
REQ-028 Reads SHALL be accepted in every state.
REQ-029 When no write is issued, buffer_write_read_n_out SHALL be 0.

Reset
REQ-030 While reset_n_in = 0 at a clock edge:
- state SHALL become IDLE;
- the skid register and any in-flight read SHALL be discarded;
- every output SHALL be 0, except read_ready_out, which SHALL be 1 after the first cycle out of reset.
REQ-031 Reset during CAPTURE SHALL abandon the frame; buffer contents are undefined.

Structure
REQ-032 Package image_buffer_pkg SHALL hold:
- the state enumeration;
- LAST_WORD_ADDRESS = 16383;
- READ_LATENCY = 3.
REQ-033 No sub-module is required; the skid register and read pipeline SHALL be implemented inline. The integration top SHALL connect this block to the buffer.

Verification
REQ-034 Capture start, 4 consecutive words 0x11223344 to 0x44556677, frame end -> write addresses 0 to 3, word_count_out = 4, capture_done_out = 1.
REQ-035 Idle, read of byte 0x0006 -> read_valid_out exactly 3 cycles after acceptance, read_data_out = byte 2 of word 1.
REQ-036 Read accepted, then pixel_valid_in during N+1 and N+2 -> both words written at N+2 and N+3, no loss, read data correct.
REQ-037 16385 words in CAPTURE -> word_count_out = 16384, overflow_out = 1, word at address 0 unchanged.
REQ-038 reset_n_in low in mid-capture with a read in flight -> state IDLE, read_valid_out never pulses, all outputs at reset values.
